csp_stage_seq: RTL

CSP_STAGE_SEQ -- requirements
Module: csp_stage_seq

---
 rtl/csp_stage_seq_pkg.sv | 25 ++
 rtl/csp_stage_seq_timer.sv | 32 +++
 rtl/csp_stage_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/csp_stage_seq_pkg.sv
// Shared types for the CSP stage sequencer: FSM states, engine stage codes,
// res_iter width and a saturating increment helper.
package csp_pkg;

    localparam int unsigned RES_ITER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        STG_CBS1 = 2'd0,
        STG_RES  = 2'd1,
        STG_CBS2 = 2'd2,
        STG_CBSO = 2'd3
    } stage_t;

    function automatic logic [RES_ITER_W-1:0] sat_inc(input logic [RES_ITER_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/csp_stage_seq_timer.sv
// WAIT-cycle watchdog for csp_stage_seq; only built with CSP_SEQ_TIMEOUT_EN.
// expired is high during the TIMEOUT-th enabled cycle after clear.
module stage_timer
    import csp_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/csp_stage_seq.sv
// Sequences CBS1 -> RES x N_RES -> CBS2 -> CBSO through a shared engine.
// Optional WAIT watchdog enabled by defining CSP_SEQ_TIMEOUT_EN.
module csp_stage_seq
    import csp_pkg::*;
#(
    parameter int unsigned N_RES   = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  eng_start,
    output logic [1:0]            eng_sel,
    input  logic                  eng_done,
    output logic                  buf_wr_en,
    output logic [1:0]            buf_sel,
    output logic [RES_ITER_W-1:0] res_iter,
    output logic                  err
);

    if (N_RES > 255) begin : g_bad_n_res
        $error("csp_stage_seq: N_RES must be in 0..255");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("csp_stage_seq: TIMEOUT must be at least 2");
    end

    localparam logic [RES_ITER_W-1:0] N_RES_B = RES_ITER_W'(N_RES);

    state_t state;
    stage_t stage;

    assign eng_sel = stage;

`ifdef CSP_SEQ_TIMEOUT_EN
    logic expired;

    stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (expired)
    );
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            stage     <= STG_CBS1;
            res_iter  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eng_start <= 1'b0;
            buf_wr_en <= 1'b0;
            buf_sel   <= '0;
`ifdef CSP_SEQ_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            eng_start <= 1'b0;
            done      <= 1'b0;
            buf_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ISSUE;
                        stage     <= STG_CBS1;
                        res_iter  <= '0;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
`ifdef CSP_SEQ_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // Completion wins over a coincident timeout.
                    if (eng_done) begin
                        buf_wr_en <= 1'b1;
                        buf_sel   <= stage;
                        if (stage == STG_CBSO) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            eng_start <= 1'b1;
                            case (stage)
                                STG_CBS1: stage <= (N_RES == 0) ? STG_CBS2 : STG_RES;
                                STG_RES: begin
                                    res_iter <= sat_inc(res_iter);
                                    stage    <= (sat_inc(res_iter) >= N_RES_B) ? STG_CBS2 : STG_RES;
                                end
                                default: stage <= STG_CBSO;
                            endcase
                        end
                    end
`ifdef CSP_SEQ_TIMEOUT_EN
                    else if (expired) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
